// File: rtl/elastic_fifo_pkg.sv
// rtl/elastic_fifo_pkg.sv - shared constants and helpers for the elastic FIFO
// Purpose: fall-through mode constants, count-width derivation, depth legality check.
// Ports: none (package).
package cgra_elastic_pkg;

  localparam int FT_OFF = 0;  // registered output, both timing paths cut
  localparam int FT_ON  = 1;  // empty FIFO forwards din to dout combinationally

  // Width needed to hold an occupancy value of 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit depth_ok(input int depth);
    return depth >= 2;
  endfunction

endpackage

// File: rtl/elastic_fifo_if.sv
// rtl/elastic_fifo_if.sv - handshake bundle between producer, FIFO and consumer
// Purpose: groups flush, input stream, output stream and occupancy.
// Ports: slave = FIFO side (drives din_r, dout, dout_v, count);
//        master = environment side (drives clr, din, din_v, dout_r).
interface elastic_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 3
);
  logic                  clr;
  logic [DATA_WIDTH-1:0] din;
  logic                  din_v;
  logic                  din_r;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_v;
  logic                  dout_r;
  logic [CNT_W-1:0]      count;

  modport slave (
    input  clr, din, din_v, dout_r,
    output din_r, dout, dout_v, count
  );

  modport master (
    output clr, din, din_v, dout_r,
    input  din_r, dout, dout_v, count
  );
endinterface

// File: rtl/elastic_fifo_mem.sv
// rtl/elastic_fifo_mem.sv - DEPTH x DATA_WIDTH register array for the elastic FIFO
// Purpose: storage with one synchronous write port and one combinational read port.
// Ports: clk, rst_n (async, active-low, clears every entry), we_i/waddr_i/wdata_i write,
//        raddr_i/rdata_o read.
module elastic_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/elastic_fifo.sv
// rtl/elastic_fifo.sv - parametrised elastic buffer with optional fall-through
// Purpose: N-entry circular FIFO breaking valid/ready paths, with sync flush and occupancy.
// Ports: clk, rst_n (async, active-low), bus (elastic_fifo_if.slave: clr, din/din_v/din_r,
//        dout/dout_v/dout_r, count).
module elastic_fifo
  import cgra_elastic_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 4,
  parameter int FALL_THROUGH = FT_OFF,
  parameter int CNT_W        = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  elastic_fifo_if.slave bus
);

  localparam int               AW   = $clog2(DEPTH);
  localparam logic [AW-1:0]    LAST = AW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_depth_chk
    $error("elastic_fifo: DEPTH must be at least 2");
  end

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  init_q;
  logic                  empty, bypass, din_r, dout_v, push, pop, we;
  logic [DATA_WIDTH-1:0] rdata;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (count_q == '0);
  assign bypass = (FALL_THROUGH == FT_ON) && empty;
  // Ready depends only on local state and clr, never on dout_r, so a pop
  // while full cannot free a slot in the same cycle.
  assign din_r  = init_q && (count_q != FULL) && !bus.clr;
  assign dout_v = bypass ? (bus.din_v && init_q && !bus.clr) : !empty;
  assign push   = bus.din_v && din_r;
  assign pop    = dout_v && bus.dout_r;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    we       = 1'b0;
    if (bus.clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (!(bypass && push && pop)) begin
      // A bypassed word that is consumed immediately never touches storage.
      if (push) begin
        we       = 1'b1;
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      init_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      init_q   <= 1'b1;
    end
  end

  elastic_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (we),
    .waddr_i(wr_ptr_q),
    .wdata_i(bus.din),
    .raddr_i(rd_ptr_q),
    .rdata_o(rdata)
  );

  // Gating the bypass on init keeps dout at zero while reset is asserted.
  assign bus.dout   = (bypass && init_q) ? bus.din : rdata;
  assign bus.dout_v = dout_v;
  assign bus.din_r  = din_r;
  assign bus.count  = count_q;

endmodule

// File: tb/tb_elastic_fifo.sv
// tb/tb_elastic_fifo.sv - self-checking bench for elastic_fifo
module tb_elastic_fifo;
  import cgra_elastic_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  elastic_fifo_if #(.DATA_WIDTH(32), .CNT_W(cnt_w(4))) if_a ();
  elastic_fifo_if #(.DATA_WIDTH(32), .CNT_W(cnt_w(4))) if_b ();
  elastic_fifo_if #(.DATA_WIDTH(32), .CNT_W(cnt_w(3))) if_c ();
  elastic_fifo_if #(.DATA_WIDTH(32), .CNT_W(cnt_w(3))) if_d ();

  elastic_fifo #(.DATA_WIDTH(32), .DEPTH(4), .FALL_THROUGH(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  elastic_fifo #(.DATA_WIDTH(32), .DEPTH(4), .FALL_THROUGH(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  elastic_fifo #(.DATA_WIDTH(32), .DEPTH(3), .FALL_THROUGH(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));
  elastic_fifo #(.DATA_WIDTH(32), .DEPTH(3), .FALL_THROUGH(1)) dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d.slave));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one ordered queue of stored words per random-phase FIFO.
  logic [31:0] mq [2][$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_cycle(input int k, input bit ft, input int depth,
                             input logic din_v, input logic dout_r, input logic clr,
                             input logic [31:0] din, input logic got_din_r,
                             input logic got_dout_v, input logic [31:0] got_dout,
                             input int got_count, input int cyc,
                             output bit do_push, output bit do_pop, output bit pass);
    int  n;
    bit  e_din_r, e_dout_v;
    n        = mq[k].size();
    pass     = ft && (n == 0);
    e_din_r  = (n != depth) && !clr;
    e_dout_v = pass ? (din_v && !clr) : (n != 0);
    chk($sformatf("rnd%0d.count@%0d", k, cyc), got_count, n);
    chk($sformatf("rnd%0d.din_r@%0d", k, cyc), got_din_r, e_din_r);
    chk($sformatf("rnd%0d.dout_v@%0d", k, cyc), got_dout_v, e_dout_v);
    if (e_dout_v)
      chk($sformatf("rnd%0d.dout@%0d", k, cyc), got_dout, pass ? din : mq[k][0]);
    do_push = din_v && e_din_r;
    do_pop  = e_dout_v && dout_r && !clr;
  endtask

  task automatic model_apply(input int k, input logic clr, input bit do_push,
                             input bit do_pop, input bit pass, input logic [31:0] din);
    if (clr) mq[k].delete();
    else if (!(pass && do_push && do_pop)) begin
      if (do_pop) void'(mq[k].pop_front());
      if (do_push) mq[k].push_back(din);
    end
  endtask

  initial begin
    logic        rv, rr, rc;
    logic [31:0] rd;
    bit          pc, oc, fc, pd, od, fd;

    {if_a.clr, if_a.din, if_a.din_v, if_a.dout_r} = '0;
    {if_c.clr, if_c.din, if_c.din_v, if_c.dout_r} = '0;
    {if_d.clr, if_d.din, if_d.din_v, if_d.dout_r} = '0;
    if_b.clr = 1'b0; if_b.din = 32'h77; if_b.din_v = 1'b1; if_b.dout_r = 1'b1;

    // Reset held for 3 cycles; outputs must be at reset values throughout.
    repeat (3) @(negedge clk);
    #1;
    chk("rst.a.din_r", if_a.din_r, 0);
    chk("rst.a.dout_v", if_a.dout_v, 0);
    chk("rst.a.dout", if_a.dout, 0);
    chk("rst.a.count", if_a.count, 0);
    chk("rst.b.dout_v", if_b.dout_v, 0);
    chk("rst.b.dout", if_b.dout, 0);
    if_b.din = '0; if_b.din_v = 1'b0; if_b.dout_r = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("startup.din_r_before_edge", if_a.din_r, 0);
    tick();
    chk("startup.din_r_after_edge", if_a.din_r, 1);

    // Fill with A0..A3, consumer stalled.
    for (int i = 0; i < 4; i++) begin
      if_a.din = 32'hA0 + i; if_a.din_v = 1'b1;
      tick();
      chk($sformatf("fill.count%0d", i), if_a.count, i + 1);
    end
    #1 chk("fill.din_r_full", if_a.din_r, 0);
    if_a.din_v = 1'b0; if_a.dout_r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("drain.dout%0d", i), if_a.dout, 32'hA0 + i);
      chk($sformatf("drain.dout_v%0d", i), if_a.dout_v, 1);
      tick();
    end
    #1 chk("drain.count", if_a.count, 0);
    chk("drain.dout_v_empty", if_a.dout_v, 0);

    // Streaming push+pop through pointer wrap.
    if_a.din_v = 1'b1; if_a.dout_r = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if_a.din = 32'hB0 + i;
      #1 if (i > 0) chk($sformatf("stream.dout%0d", i), if_a.dout, 32'hB0 + i - 1);
      tick();
      chk($sformatf("stream.count%0d", i), if_a.count, 1);
    end
    if_a.din_v = 1'b0;
    #1 chk("stream.last", if_a.dout, 32'hB9);
    tick();
    chk("stream.count_end", if_a.count, 0);

    // Full with concurrent pop: no push that cycle.
    if_a.dout_r = 1'b0; if_a.din_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_a.din = 32'hC0 + i;
      tick();
    end
    if_a.din = 32'hCF; if_a.dout_r = 1'b1;
    #1 chk("full_pop.din_r", if_a.din_r, 0);
    tick();
    chk("full_pop.count", if_a.count, 3);
    chk("full_pop.dout", if_a.dout, 32'hC1);
    if_a.din_v = 1'b0;
    repeat (3) tick();
    chk("full_pop.drained", if_a.count, 0);

    // Flush at count 3 with concurrent push and pop requests.
    if_a.dout_r = 1'b0; if_a.din_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_a.din = 32'hD0 + i;
      tick();
    end
    if_a.clr = 1'b1; if_a.dout_r = 1'b1; if_a.din = 32'hDF;
    #1 chk("flush.din_r", if_a.din_r, 0);
    chk("flush.dout_v_during", if_a.dout_v, 1);
    tick();
    if_a.clr = 1'b0; if_a.din_v = 1'b0; if_a.dout_r = 1'b0;
    #1 chk("flush.count", if_a.count, 0);
    chk("flush.dout_v", if_a.dout_v, 0);
    if_a.din = 32'hE0; if_a.din_v = 1'b1;
    tick();
    if_a.din_v = 1'b0;
    chk("flush.after_push", if_a.dout, 32'hE0);

    // Fall-through: empty, same-cycle forward and consume.
    if_b.din = 32'h55; if_b.din_v = 1'b1; if_b.dout_r = 1'b1;
    #1 chk("ft.dout_v", if_b.dout_v, 1);
    chk("ft.dout", if_b.dout, 32'h55);
    tick();
    chk("ft.count", if_b.count, 0);
    if_b.din = 32'h66; if_b.dout_r = 1'b0;
    #1 chk("ft.fwd_stall", if_b.dout, 32'h66);
    tick();
    if_b.din = 32'h67;
    #1 chk("ft.stored_count", if_b.count, 1);
    chk("ft.stored_dout", if_b.dout, 32'h66);
    if_b.din_v = 1'b0; if_b.dout_r = 1'b1;
    tick();
    if_b.dout_r = 1'b0; if_b.din_v = 1'b1; if_b.clr = 1'b1;
    #1 chk("ft.clr_empty_dout_v", if_b.dout_v, 0);
    tick();
    if_b.clr = 1'b0; if_b.din_v = 1'b0;

    // Randomized traffic on DEPTH=3 in both modes against the queue model.
    for (int i = 0; i < 10000; i++) begin
      rv = ($urandom_range(0, 3) < (((i / 700) % 2 == 0) ? 3 : 1));
      rr = ($urandom_range(0, 3) < (((i / 700) % 2 == 0) ? 1 : 3));
      rc = ($urandom_range(0, 149) == 0);
      rd = $urandom;
      if_c.din_v = rv; if_c.dout_r = rr; if_c.clr = rc; if_c.din = rd;
      if_d.din_v = rv; if_d.dout_r = rr; if_d.clr = rc; if_d.din = rd;
      #1;
      model_cycle(0, 1'b0, 3, rv, rr, rc, rd, if_c.din_r, if_c.dout_v, if_c.dout,
                  int'(if_c.count), i, pc, oc, fc);
      model_cycle(1, 1'b1, 3, rv, rr, rc, rd, if_d.din_r, if_d.dout_v, if_d.dout,
                  int'(if_d.count), i, pd, od, fd);
      @(posedge clk);
      model_apply(0, rc, pc, oc, fc, rd);
      model_apply(1, rc, pd, od, fd, rd);
      @(negedge clk);
    end

    // Asynchronous reset mid-operation with traffic pending.
    if_c.din_v = 1'b1; if_d.din_v = 1'b1; if_c.clr = 1'b0; if_d.clr = 1'b0;
    if_c.dout_r = 1'b0; if_d.dout_r = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst.c.count", if_c.count, 0);
    chk("arst.c.dout_v", if_c.dout_v, 0);
    chk("arst.c.din_r", if_c.din_r, 0);
    chk("arst.c.dout", if_c.dout, 0);
    chk("arst.d.dout_v", if_d.dout_v, 0);
    chk("arst.d.dout", if_d.dout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/elastic_fifo.md
# elastic_fifo

Parametrised elastic buffer for CGRA interconnect and PE input/output ports. It is the deeper, configurable successor to the two-slot elastic buffer: N-entry circular storage, optional fall-through mode, synchronous flush and an occupancy output. It breaks valid and ready timing paths between producer and consumer. With `FALL_THROUGH=0`, it cuts the combinational path in both directions.

## Interface
- `DATA_WIDTH`, 32, payload width in bits.
- `DEPTH`, 4, storage entries; legal range ≥2, need not be a power of two.
- `FALL_THROUGH`, 0, 1 = empty FIFO forwards `din` to `dout` combinationally.
- `CNT_W`, `$clog2(DEPTH+1)`, derived width of `count`; not to be overridden.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `clr` input 1: synchronous flush, active-high.
- `din` input DATA_WIDTH: input payload.
- `din_v` input 1: input valid.
- `din_r` output 1: input ready.
- `dout` output DATA_WIDTH: output payload.
- `dout_v` output 1: output valid.
- `dout_r` input 1: output ready.
- `count` output CNT_W: entries currently stored.

## Operation
- **Transfers.**
  - A push occurs when `din_v && din_r` at a rising edge.
  - A pop occurs when `dout_v && dout_r` at a rising edge.
  - `din_v` and `din` are not required to hold when `din_r=0`, but the producer normally holds them.
- **State.** `wr_ptr`, `rd_ptr` (0..DEPTH-1), `count` (0..DEPTH), storage `mem[DEPTH]`, and an `init` flop.
- **Pointer wrap.** A pointer at DEPTH-1 wraps to 0 explicitly. Modulo-2^n wrap is not used.
- **Ready.** `din_r = init && (count != DEPTH) && !clr`.
  - `din_r` has no combinational dependence on `dout_r` in either mode.
- **Standard mode (`FALL_THROUGH=0`).**
  - `dout_v = (count != 0)`.
  - `dout = mem[rd_ptr]`.
  - Push writes `mem[wr_ptr]` and increments `wr_ptr`. Pop increments `rd_ptr`.
  - Count update: push only +1, pop only −1, push and pop together unchanged.
- **Fall-through mode (`FALL_THROUGH=1`), when `count==0`:**
  - `dout_v = din_v && init && !clr`, and `dout = din`.
  - If the pop and push happen in the same cycle, nothing is written and pointers and count are unchanged.
  - If the push happens without a pop, the word is stored as in standard mode.
- **Fall-through mode, when `count!=0`:** identical to standard mode.
- **Full.** With `count==DEPTH`, a pop in the same cycle does not allow a push; `din_r` stays 0 for that cycle. This is deliberate: it keeps `din_r` free of a path from `dout_r`.
- **Flush (`clr=1`).**
  - At the edge, pointers and count go to 0.
  - Any concurrent push or pop is discarded.
  - `mem` contents are not cleared.
  - During the `clr` cycle, `din_r=0`. `dout_v` stays as computed in standard mode; in fall-through mode it is forced 0 only when the FIFO is empty.

## Timing
- **Reset (`rst_n` low).**
  - `count=0`, pointers 0, `mem` all 0, `init=0`.
  - Outputs: `din_r=0`, `dout_v=0`, `dout=0`.
- **After reset release.**
  - `init` sets at the first rising edge.
  - `din_r` first goes to 1 in the cycle after that edge.
- **Latency.**
  - Standard mode: 1 cycle from push edge to `dout_v`.
  - Fall-through mode: 0 cycles when empty, otherwise 1.
- **Throughput.** 1 word per cycle sustained while `0 < count < DEPTH`.
- **Reset mid-operation.** Asynchronous. All state is lost immediately and outputs take their reset values within the same cycle.

## Structure
- **Package `cgra_elastic_pkg`:**
  - `cnt_w(depth)` function.
  - `FALL_THROUGH` mode constants.
  - Elaboration check `DEPTH>=2`.
- **Sub-module `elastic_fifo_mem`:**
  - DEPTH × DATA_WIDTH register array, async-reset to 0.
  - Single write port (`we`, `waddr`, `wdata`) and one combinational read port (`raddr`, `rdata`).
- **Top level:** pointers, count, `init` and the handshake logic.

## Test plan
- **Reset and startup.** Hold `rst_n` low 3 cycles, then release → `din_r=0`, `dout_v=0`, `dout=0`, `count=0` during reset. `din_r=1` from the second cycle after release.
- **Fill and drain, DEPTH=4.** Push 0xA0..0xA3 with `dout_r=0` → `count` goes 1,2,3,4 and `din_r=0` at 4. Then set `dout_r=1` → pops A0..A3 in order on 4 consecutive cycles, `count` back to 0.
- **Wrap and concurrency.**
  - Push and pop every cycle for 10 words → `count` steady at 1 (standard mode), pointers wrap past 3, data order preserved.
  - At `count=4` with `dout_r=1` → no push that cycle, `count=3`.
- **Fall-through.** `FALL_THROUGH=1`, empty, `din=0x55`, `din_v=1`, `dout_r=1` → `dout=0x55`, `dout_v=1` in the same cycle; `count` stays 0.
- **Flush.** `count=3`, assert `clr` with `din_v=1` and `dout_r=1` → next cycle `count=0`, `dout_v=0`, no word accepted or popped.
- **Random backpressure.** `DEPTH=3` (non-power-of-two), random `din_v`/`dout_r` for 10k cycles → scoreboard shows in-order, lossless, duplicate-free delivery and `count` equal to the model.
